// File: rtl/ts_submit_manage_module_pkg.sv
// Shared definitions for the TS submit manager.
// Provides the descriptor/address widths, the counter width, the FSM state
// encoding and a saturating-increment helper for the statistics counters.
package ts_submit_manage_module_pkg;

    localparam int DESC_W = 40;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_OUTPUT = 2'd2
    } tsm_state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ts_submit_manage_module_table.sv
// ts_desc_table: descriptor storage with a per-entry valid bitmap.
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset (valid bits only)
//   i_wr, iv_wr_addr, iv_wr_data write port; ignored if the entry is occupied
//   i_clr, iv_rd_addr           combinational read port, clears valid at edge
//   ov_rd_data, o_rd_valid      data/valid of entry iv_rd_addr
//   ov_valid                    whole valid bitmap
//   o_wr_drop                   current write is being rejected
module ts_desc_table
    import ts_submit_manage_module_pkg::*;
#(
    parameter int DESC_W_P = DESC_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr,
    input  logic [ADDR_W_P-1:0]        iv_wr_addr,
    input  logic [DESC_W_P-1:0]        iv_wr_data,
    input  logic                       i_clr,
    input  logic [ADDR_W_P-1:0]        iv_rd_addr,
    output logic [DESC_W_P-1:0]        ov_rd_data,
    output logic                       o_rd_valid,
    output logic [(1<<ADDR_W_P)-1:0]   ov_valid,
    output logic                       o_wr_drop
);

    localparam int DEPTH = 1 << ADDR_W_P;

    logic [DEPTH-1:0][DESC_W_P-1:0] mem;
    logic [DEPTH-1:0]               valid;
    logic [DEPTH-1:0]               valid_nxt;
    logic                           clr_same;
    logic                           wr_ok;

    assign ov_rd_data = mem[iv_rd_addr];
    assign o_rd_valid = valid[iv_rd_addr];
    assign ov_valid   = valid;

    // Consume-then-write: an entry being cleared this cycle counts as free,
    // so a same-entry write lands behind the consume instead of dropping.
    assign clr_same  = i_clr && (iv_rd_addr == iv_wr_addr);
    assign o_wr_drop = i_wr && valid[iv_wr_addr] && !clr_same;
    assign wr_ok     = i_wr && !o_wr_drop;

    always_comb begin
        valid_nxt = valid;
        if (i_clr) valid_nxt[iv_rd_addr] = 1'b0;
        if (wr_ok) valid_nxt[iv_wr_addr] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) valid <= '0;
        else          valid <= valid_nxt;
    end

    // Data array is not reset; valid bits gate every use of it.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[iv_wr_addr] <= iv_wr_data;
    end

endmodule

// File: rtl/ts_submit_manage_module.sv
// ts_submit_manage_module: caches TS packet descriptors written by the host
// and hands them to the transmit stage on schedule requests.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_ts_descriptor_wr/addr/descriptor  host descriptor write
//   i_ts_submit_addr_wr/iv_ts_submit_addr, o_ts_submit_addr_ack
//                                       schedule request / one-cycle ack
//   ov_ts_descriptor, o_ts_descriptor_wr, i_ts_descriptor_ready
//                                       valid/ready descriptor output
//   ov_entry_valid                      per-entry valid bitmap
//   ov_miss_cnt, ov_drop_cnt            saturating statistics
//   ov_tsm_state                        FSM state for debug
module ts_submit_manage_module
    import ts_submit_manage_module_pkg::*;
#(
    parameter int DESC_W = ts_submit_manage_module_pkg::DESC_W,
    parameter int ADDR_W = ts_submit_manage_module_pkg::ADDR_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ts_descriptor_wr,
    input  logic [ADDR_W-1:0]         iv_ts_descriptor_addr,
    input  logic [DESC_W-1:0]         iv_ts_descriptor,
    input  logic                      i_ts_submit_addr_wr,
    input  logic [ADDR_W-1:0]         iv_ts_submit_addr,
    output logic                      o_ts_submit_addr_ack,
    output logic [DESC_W-1:0]         ov_ts_descriptor,
    output logic                      o_ts_descriptor_wr,
    input  logic                      i_ts_descriptor_ready,
    output logic [(1<<ADDR_W)-1:0]    ov_entry_valid,
    output logic [CNT_W-1:0]          ov_miss_cnt,
    output logic [CNT_W-1:0]          ov_drop_cnt,
    output logic [1:0]                ov_tsm_state
);

    tsm_state_e          state;
    logic [ADDR_W-1:0]   sub_addr;
    logic [DESC_W-1:0]   rd_data;
    logic                rd_valid;
    logic                wr_drop;
    logic                lookup;

    assign lookup       = (state == ST_LOOKUP);
    assign ov_tsm_state = state;

    ts_desc_table #(
        .DESC_W_P (DESC_W),
        .ADDR_W_P (ADDR_W)
    ) u_table (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr       (i_ts_descriptor_wr),
        .iv_wr_addr (iv_ts_descriptor_addr),
        .iv_wr_data (iv_ts_descriptor),
        .i_clr      (lookup),
        .iv_rd_addr (sub_addr),
        .ov_rd_data (rd_data),
        .o_rd_valid (rd_valid),
        .ov_valid   (ov_entry_valid),
        .o_wr_drop  (wr_drop)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= ST_IDLE;
            sub_addr             <= '0;
            o_ts_submit_addr_ack <= 1'b0;
            o_ts_descriptor_wr   <= 1'b0;
            ov_ts_descriptor     <= '0;
            ov_miss_cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_ts_submit_addr_ack <= 1'b0;
                    if (i_ts_submit_addr_wr) begin
                        sub_addr             <= iv_ts_submit_addr;
                        o_ts_submit_addr_ack <= 1'b1;
                        state                <= ST_LOOKUP;
                    end
                end
                // The table clears the entry at this edge whether or not it hit.
                ST_LOOKUP: begin
                    o_ts_submit_addr_ack <= 1'b0;
                    if (rd_valid) begin
                        ov_ts_descriptor   <= rd_data;
                        o_ts_descriptor_wr <= 1'b1;
                        state              <= ST_OUTPUT;
                    end else begin
                        ov_miss_cnt <= sat_inc(ov_miss_cnt);
                        state       <= ST_IDLE;
                    end
                end
                ST_OUTPUT: begin
                    if (i_ts_descriptor_ready) begin
                        o_ts_descriptor_wr <= 1'b0;
                        state              <= ST_IDLE;
                    end
                end
                default: begin
                    o_ts_submit_addr_ack <= 1'b0;
                    o_ts_descriptor_wr   <= 1'b0;
                    ov_ts_descriptor     <= '0;
                    state                <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     ov_drop_cnt <= '0;
        else if (wr_drop) ov_drop_cnt <= sat_inc(ov_drop_cnt);
    end

endmodule

// File: tb/tb_ts_submit_manage_module.sv
module tb_ts_submit_manage_module;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ts_descriptor_wr = 1'b0;
    logic [4:0]  iv_ts_descriptor_addr = '0;
    logic [39:0] iv_ts_descriptor = '0;
    logic        i_ts_submit_addr_wr = 1'b0;
    logic [4:0]  iv_ts_submit_addr = '0;
    logic        o_ts_submit_addr_ack;
    logic [39:0] ov_ts_descriptor;
    logic        o_ts_descriptor_wr;
    logic        i_ts_descriptor_ready = 1'b0;
    logic [31:0] ov_entry_valid;
    logic [15:0] ov_miss_cnt;
    logic [15:0] ov_drop_cnt;
    logic [1:0]  ov_tsm_state;

    int vecs = 0;
    int errs = 0;
    logic [39:0] exp_q[$];

    localparam logic [39:0] D3  = 40'h12_3456_789A;
    localparam logic [39:0] D9  = 40'hAB_CDEF_0123;
    localparam logic [39:0] D5A = 40'h55_AAAA_0001;
    localparam logic [39:0] D5B = 40'h55_BBBB_0002;
    localparam logic [39:0] D5C = 40'h55_CCCC_0003;
    localparam logic [39:0] D11 = 40'h11_1111_1111;
    localparam logic [39:0] D13 = 40'h13_1313_1313;

    ts_submit_manage_module dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_ts_descriptor_wr    (i_ts_descriptor_wr),
        .iv_ts_descriptor_addr (iv_ts_descriptor_addr),
        .iv_ts_descriptor      (iv_ts_descriptor),
        .i_ts_submit_addr_wr   (i_ts_submit_addr_wr),
        .iv_ts_submit_addr     (iv_ts_submit_addr),
        .o_ts_submit_addr_ack  (o_ts_submit_addr_ack),
        .ov_ts_descriptor      (ov_ts_descriptor),
        .o_ts_descriptor_wr    (o_ts_descriptor_wr),
        .i_ts_descriptor_ready (i_ts_descriptor_ready),
        .ov_entry_valid        (ov_entry_valid),
        .ov_miss_cnt           (ov_miss_cnt),
        .ov_drop_cnt           (ov_drop_cnt),
        .ov_tsm_state          (ov_tsm_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [39:0] d);
        i_ts_descriptor_wr    = 1'b1;
        iv_ts_descriptor_addr = a;
        iv_ts_descriptor      = d;
        step();
        i_ts_descriptor_wr    = 1'b0;
    endtask

    // Scoreboard: pop on every accepted descriptor handshake.
    always @(posedge i_clk) begin
        if (i_rst_n && o_ts_descriptor_wr && i_ts_descriptor_ready) begin
            if (exp_q.size() == 0) chk("unexpected_desc", 64'(ov_ts_descriptor), 64'hDEAD);
            else chk("sb_desc", 64'(ov_ts_descriptor), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(); step();
        chk("rst_state", 64'(ov_tsm_state), 64'd0);
        chk("rst_bitmap", 64'(ov_entry_valid), 64'd0);
        chk("rst_miss", 64'(ov_miss_cnt), 64'd0);
        chk("rst_drop", 64'(ov_drop_cnt), 64'd0);
        chk("rst_ack", 64'(o_ts_submit_addr_ack), 64'd0);
        chk("rst_wr", 64'(o_ts_descriptor_wr), 64'd0);
        chk("rst_desc", 64'(ov_ts_descriptor), 64'd0);
        i_rst_n = 1'b1;
        step();

        // Hit on entry 3; request held one cycle past ack to show no re-accept
        host_wr(5'd3, D3);
        chk("hit_valid_set", 64'(ov_entry_valid[3]), 64'd1);
        i_ts_descriptor_ready = 1'b1;
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd3;
        exp_q.push_back(D3);
        step();
        chk("hit_ack", 64'(o_ts_submit_addr_ack), 64'd1);
        chk("hit_lookup", 64'(ov_tsm_state), 64'd1);
        chk("hit_wr_early", 64'(o_ts_descriptor_wr), 64'd0);
        step();
        i_ts_submit_addr_wr = 1'b0;
        chk("hit_ack_once", 64'(o_ts_submit_addr_ack), 64'd0);
        chk("hit_wr", 64'(o_ts_descriptor_wr), 64'd1);
        chk("hit_desc", 64'(ov_ts_descriptor), 64'(D3));
        chk("hit_valid_clr", 64'(ov_entry_valid[3]), 64'd0);
        step();
        chk("hit_wr_done", 64'(o_ts_descriptor_wr), 64'd0);
        chk("hit_idle", 64'(ov_tsm_state), 64'd0);

        // Miss on empty entry 7
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd7;
        step();
        i_ts_submit_addr_wr = 1'b0;
        chk("miss_ack", 64'(o_ts_submit_addr_ack), 64'd1);
        step();
        chk("miss_ack_once", 64'(o_ts_submit_addr_ack), 64'd0);
        chk("miss_no_wr", 64'(o_ts_descriptor_wr), 64'd0);
        chk("miss_idle", 64'(ov_tsm_state), 64'd0);
        chk("miss_cnt", 64'(ov_miss_cnt), 64'd1);

        // Backpressure on entry 9
        host_wr(5'd9, D9);
        i_ts_descriptor_ready = 1'b0;
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd9;
        exp_q.push_back(D9);
        step();
        i_ts_submit_addr_wr = 1'b0;
        chk("bp_ack", 64'(o_ts_submit_addr_ack), 64'd1);
        step();
        chk("bp_output", 64'(ov_tsm_state), 64'd2);
        for (int i = 0; i < 10; i++) begin
            i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd9;
            step();
            chk("bp_wr_hold", 64'(o_ts_descriptor_wr), 64'd1);
            chk("bp_desc_hold", 64'(ov_ts_descriptor), 64'(D9));
            chk("bp_no_ack", 64'(o_ts_submit_addr_ack), 64'd0);
        end
        i_ts_submit_addr_wr = 1'b0;
        i_ts_descriptor_ready = 1'b1;
        step();
        chk("bp_release_wr", 64'(o_ts_descriptor_wr), 64'd0);
        chk("bp_release_idle", 64'(ov_tsm_state), 64'd0);
        chk("bp_queue_drained", 64'(exp_q.size()), 64'd0);

        // Collision on entry 5
        host_wr(5'd5, D5A);
        host_wr(5'd5, D5B);
        chk("coll_drop", 64'(ov_drop_cnt), 64'd1);
        chk("coll_valid", 64'(ov_entry_valid[5]), 64'd1);
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd5;
        exp_q.push_back(D5A);
        step();
        i_ts_submit_addr_wr = 1'b0;
        chk("coll_ack", 64'(o_ts_submit_addr_ack), 64'd1);
        host_wr(5'd5, D5C);           // lands on the LOOKUP edge
        chk("coll_old_desc", 64'(ov_ts_descriptor), 64'(D5A));
        chk("coll_new_valid", 64'(ov_entry_valid[5]), 64'd1);
        chk("coll_drop_same", 64'(ov_drop_cnt), 64'd1);
        step();
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd5;
        exp_q.push_back(D5C);
        step();
        i_ts_submit_addr_wr = 1'b0;
        step();
        chk("coll_new_desc", 64'(ov_ts_descriptor), 64'(D5C));
        step();

        // Write racing a LOOKUP of an empty entry
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd11;
        step();
        i_ts_submit_addr_wr = 1'b0;
        host_wr(5'd11, D11);
        chk("race_miss", 64'(ov_miss_cnt), 64'd2);
        chk("race_no_wr", 64'(o_ts_descriptor_wr), 64'd0);
        chk("race_valid", 64'(ov_entry_valid[11]), 64'd1);
        chk("race_drop", 64'(ov_drop_cnt), 64'd1);
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd11;
        exp_q.push_back(D11);
        step();
        i_ts_submit_addr_wr = 1'b0;
        step();
        chk("race_desc", 64'(ov_ts_descriptor), 64'(D11));
        step();

        // Reset during OUTPUT
        host_wr(5'd13, D13);
        host_wr(5'd20, D3);
        i_ts_descriptor_ready = 1'b0;
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd13;
        step();
        i_ts_submit_addr_wr = 1'b0;
        step();
        chk("rst_pre_output", 64'(ov_tsm_state), 64'd2);
        i_rst_n = 1'b0;
        #1;
        chk("arst_wr", 64'(o_ts_descriptor_wr), 64'd0);
        chk("arst_bitmap", 64'(ov_entry_valid), 64'd0);
        chk("arst_miss", 64'(ov_miss_cnt), 64'd0);
        chk("arst_drop", 64'(ov_drop_cnt), 64'd0);
        chk("arst_state", 64'(ov_tsm_state), 64'd0);
        step();
        i_rst_n = 1'b1;
        i_ts_descriptor_ready = 1'b1;
        i_ts_submit_addr_wr = 1'b1; iv_ts_submit_addr = 5'd13;
        step();
        i_ts_submit_addr_wr = 1'b0;
        chk("post_rst_ack", 64'(o_ts_submit_addr_ack), 64'd1);
        step();
        chk("post_rst_no_wr", 64'(o_ts_descriptor_wr), 64'd0);
        chk("post_rst_miss", 64'(ov_miss_cnt), 64'd1);
        step();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ts_submit_manage_module.md
TS_SUBMIT_MANAGE_MODULE -- requirements
Module: ts_submit_manage_module

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
  DESC_W  40  descriptor width
  ADDR_W  5  submit-address width; table depth is 2^ADDR_W = 32
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
  i_clk  in  1  clock
  i_rst_n  in  1  reset, asynchronous, active-low
  i_ts_descriptor_wr  in  1  host-side descriptor write strobe
  iv_ts_descriptor_addr  in  5  entry written
  iv_ts_descriptor  in  DESC_W  descriptor of cached TS packet
  i_ts_submit_addr_wr  in  1  schedule request; held high until ack
  iv_ts_submit_addr  in  5  entry to submit
  o_ts_submit_addr_ack  out  1  one-cycle request acceptance pulse
  ov_ts_descriptor  out  DESC_W  descriptor to transmit stage
  o_ts_descriptor_wr  out  1  descriptor valid; held until ready
  i_ts_descriptor_ready  in  1  transmit stage accepts
  ov_entry_valid  out  32  per-entry valid bitmap
  ov_miss_cnt  out  16  requests to empty entries
  ov_drop_cnt  out  16  writes rejected because the entry was occupied
  ov_tsm_state  out  2  FSM state, for debug

Function
REQ-003 The storage SHALL be 32 entries of DESC_W bits, each with a valid bit.
REQ-004 A write to an invalid entry SHALL store the data and set the valid bit at the next edge.
REQ-005 A write to a valid entry SHALL be discarded, and ov_drop_cnt SHALL increment.
REQ-006 The FSM SHALL have the states IDLE=0, LOOKUP=1 and OUTPUT=2. Encoding 3 SHALL return to IDLE with all outputs cleared.
REQ-007 IDLE: when i_ts_submit_addr_wr=1, the block SHALL latch the address, pulse o_ts_submit_addr_ack for exactly one cycle, and go to LOOKUP.
REQ-008 Requests SHALL be ignored outside IDLE.
REQ-009 The block SHALL NOT accept the same request twice: the cycle after the ack, the FSM is already in LOOKUP.
REQ-010 LOOKUP, entry valid: the block SHALL load ov_ts_descriptor, set o_ts_descriptor_wr, clear the entry's valid bit, and go to OUTPUT.
REQ-011 LOOKUP, entry invalid: ov_miss_cnt SHALL increment, no descriptor SHALL be emitted, and the FSM SHALL return to IDLE.
REQ-012 OUTPUT: the block SHALL hold o_ts_descriptor_wr and ov_ts_descriptor stable until i_ts_descriptor_ready=1.
REQ-013 On the edge where ready=1 in OUTPUT, o_ts_descriptor_wr SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-014 Minimum latency SHALL be: request sampled at edge N -> ack high at N+1 -> o_ts_descriptor_wr high at N+2.
REQ-015 A write and a LOOKUP clear of the same entry in the same cycle SHALL be ordered consume-then-write:
  - the old descriptor (if valid) is emitted;
  - the new data is stored with valid=1;
  - no drop is counted.
REQ-016 A write and a LOOKUP of an invalid entry in the same cycle SHALL count a miss and store the new data with valid=1.
REQ-017 Writes SHALL be accepted in every FSM state.
REQ-018 ov_miss_cnt and ov_drop_cnt SHALL saturate at 16'hFFFF.
REQ-019 Address arithmetic SHALL be 5-bit, with no wrap logic needed.

Reset
REQ-020 Asynchronous assertion SHALL force:
  - FSM to IDLE;
  - all valid bits, both counters, o_ts_submit_addr_ack, o_ts_descriptor_wr and ov_ts_descriptor to 0.
REQ-021 Reset mid-OUTPUT SHALL drop the pending descriptor; the entry it came from remains invalid.
REQ-022 Descriptor data bits MAY be left unreset; valid bits SHALL be reset.

Structure
REQ-023 A shared package SHALL hold DESC_W, ADDR_W, the FSM state encodings and the counter width.
REQ-024 Storage and valid bitmap SHALL be one sub-module, ts_desc_table, with:
  - one write port;
  - one combinational-read/clear port;
  - consume-then-write priority inside the sub-module.
REQ-025 The FSM, handshakes and counters SHALL live in the top level.

Verification
REQ-026 Hit: write entry 3 = 40'h12_3456_789A; request addr 3 with ready=1 -> ack at N+1; wr=1 with 40'h12_3456_789A at N+2; ov_entry_valid[3]=0 afterwards.
REQ-027 Miss: request addr 7 while empty -> one ack, no descriptor, ov_miss_cnt=1, FSM back to IDLE at N+2.
REQ-028 Backpressure: hold ready=0 for 10 cycles in OUTPUT -> wr and data stable throughout; new requests get no ack; release ready -> IDLE.
REQ-029 Collision: write entry 5 twice with no consume -> first data retained, ov_drop_cnt=1. Same-cycle write plus LOOKUP of entry 5 -> old data emitted, new data valid, drop count unchanged.
REQ-030 Reset: assert i_rst_n=0 during OUTPUT -> wr=0, bitmap=0, counters=0 immediately. After release, a request to that entry counts a miss.
